cbm2_mem_arbiter: RTL



---
 rtl/cbm2_mem_arbiter_pkg.sv | 6 +
 rtl/cbm2_mem_arbiter_if.sv | 11 +
 rtl/cbm2_req_latch.sv | 37 +++
 rtl/cbm2_mem_arbiter.sv | 109 ++++++++++
 4 files changed

// File: rtl/cbm2_mem_arbiter_pkg.sv
// cbm2_pkg: shared request ids, arbiter FSM states and the read data returned on timeout
package cbm2_pkg;
  typedef enum logic [1:0] {REQ_VID, REQ_CPU, REQ_LDR} req_id_t;
  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} arb_state_t;
  localparam logic [7:0] TIMEOUT_DATA = 8'hFF;
endpackage

// File: rtl/cbm2_mem_arbiter_if.sv
// cbm2_mem_arbiter_if: external memory port (master drives mem_req/addr/we/wdata, slave returns mem_ack/mem_rdata)
interface cbm2_mem_arbiter_if #(parameter int ADDR_W = 25);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [7:0]        mem_wdata;
  logic              mem_ack;
  logic [7:0]        mem_rdata;
  modport master(output mem_req, mem_addr, mem_we, mem_wdata, input mem_ack, mem_rdata);
  modport slave(input mem_req, mem_addr, mem_we, mem_wdata, output mem_ack, mem_rdata);
endinterface

// File: rtl/cbm2_req_latch.sv
// cbm2_req_latch: one-deep request latch (strobe req/addr_in/we_in/wdata_in, clear clr) -> pending + held request, sticky overrun
module cbm2_req_latch #(
  parameter int ADDR_W = 25
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              req,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic              we_in,
  input  logic [7:0]        wdata_in,
  input  logic              clr,
  output logic              pending,
  output logic [ADDR_W-1:0] addr,
  output logic              we,
  output logic [7:0]        wdata,
  output logic              overrun
);
  logic held;
  assign held = pending & ~clr;
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      pending <= 1'b0;
      addr    <= '0;
      we      <= 1'b0;
      wdata   <= '0;
      overrun <= 1'b0;
    end else begin
      if (req && !held) begin
        pending <= 1'b1;
        addr    <= addr_in;
        we      <= we_in;
        wdata   <= wdata_in;
      end else if (clr) pending <= 1'b0;
      if (req && held) overrun <= 1'b1;
    end
  end
endmodule

// File: rtl/cbm2_mem_arbiter.sv
// cbm2_mem_arbiter: shares one memory port (mem) among vid/cpu/ldr requesters with per-requester ack/rdata, sticky err_timeout/err_overrun
module cbm2_mem_arbiter
  import cbm2_pkg::*;
#(
  parameter int ADDR_W       = 25,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 64
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              vid_req,
  input  logic              cpu_req,
  input  logic              ldr_req,
  input  logic [ADDR_W-1:0] vid_addr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic              cpu_we,
  input  logic              ldr_we,
  input  logic [7:0]        cpu_wdata,
  input  logic [7:0]        ldr_wdata,
  output logic              vid_ack,
  output logic              cpu_ack,
  output logic              ldr_ack,
  output logic [7:0]        vid_rdata,
  output logic [7:0]        cpu_rdata,
  output logic [7:0]        ldr_rdata,
  cbm2_mem_arbiter_if.master mem,
  output logic              err_timeout,
  output logic [2:0]        err_overrun
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  arb_state_t        state;
  req_id_t           grant, pick;
  logic [2:0]        pend, ack_q;
  logic [ADDR_W-1:0] v_addr, c_addr, l_addr, sel_addr;
  logic              v_we, c_we, l_we, sel_we;
  logic [7:0]        v_wd, c_wd, l_wd, sel_wd;
  logic [7:0]        rdata [3];
  logic [TW-1:0]     wait_cnt;
  logic [SW-1:0]     starve_cnt;
  logic              starved, timed_out;
  cbm2_req_latch #(.ADDR_W(ADDR_W)) u_vid (
    .clk_sys(clk_sys), .reset_n(reset_n), .req(vid_req), .addr_in(vid_addr), .we_in(1'b0),
    .wdata_in(8'h00), .clr(ack_q[0]), .pending(pend[0]), .addr(v_addr), .we(v_we), .wdata(v_wd),
    .overrun(err_overrun[0]));
  cbm2_req_latch #(.ADDR_W(ADDR_W)) u_cpu (
    .clk_sys(clk_sys), .reset_n(reset_n), .req(cpu_req), .addr_in(cpu_addr), .we_in(cpu_we),
    .wdata_in(cpu_wdata), .clr(ack_q[1]), .pending(pend[1]), .addr(c_addr), .we(c_we), .wdata(c_wd),
    .overrun(err_overrun[1]));
  cbm2_req_latch #(.ADDR_W(ADDR_W)) u_ldr (
    .clk_sys(clk_sys), .reset_n(reset_n), .req(ldr_req), .addr_in(ldr_addr), .we_in(ldr_we),
    .wdata_in(ldr_wdata), .clr(ack_q[2]), .pending(pend[2]), .addr(l_addr), .we(l_we), .wdata(l_wd),
    .overrun(err_overrun[2]));
  assign starved   = pend[2] && starve_cnt == SW'(STARVE_LIMIT);
  assign timed_out = wait_cnt == TW'(TIMEOUT - 1);
  always_comb begin
    pick     = pend[0] ? REQ_VID : (pend[1] && !starved) ? REQ_CPU : REQ_LDR;
    sel_addr = pick == REQ_VID ? v_addr : pick == REQ_CPU ? c_addr : l_addr;
    sel_we   = pick == REQ_VID ? v_we : pick == REQ_CPU ? c_we : l_we;
    sel_wd   = pick == REQ_VID ? v_wd : pick == REQ_CPU ? c_wd : l_wd;
  end
  assign {ldr_ack, cpu_ack, vid_ack} = ack_q;
  assign vid_rdata = rdata[0];
  assign cpu_rdata = rdata[1];
  assign ldr_rdata = rdata[2];
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      grant         <= REQ_VID;
      ack_q         <= '0;
      rdata         <= '{default: '0};
      wait_cnt      <= '0;
      starve_cnt    <= '0;
      err_timeout   <= 1'b0;
      mem.mem_req   <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_we    <= 1'b0;
      mem.mem_wdata <= '0;
    end else begin
      ack_q <= '0;
      if (!pend[2]) starve_cnt <= '0;
      unique case (state)
        ST_IDLE: if (|pend) begin
          state         <= ST_BUSY;
          grant         <= pick;
          wait_cnt      <= '0;
          mem.mem_req   <= 1'b1;
          mem.mem_addr  <= sel_addr;
          mem.mem_we    <= sel_we;
          mem.mem_wdata <= sel_wd;
          if (pick == REQ_LDR) starve_cnt <= '0;
          else if (pick == REQ_CPU && pend[2] && !starved) starve_cnt <= starve_cnt + 1'b1;
        end
        ST_BUSY: begin
          wait_cnt <= wait_cnt + 1'b1;
          if (mem.mem_ack || timed_out) begin
            state       <= ST_DONE;
            mem.mem_req <= 1'b0;
            ack_q       <= 3'b001 << grant;
            if (!mem.mem_we) rdata[grant] <= mem.mem_ack ? mem.mem_rdata : TIMEOUT_DATA;
            if (!mem.mem_ack) err_timeout <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule
